decoder_seq: RTL

Parametrised registered SEL_W-to-2^SEL_W one-hot decoder with built-in sequencing, the next generation of the team's 2:4 enable-gated decoder. It supports three modes: direct registered decode of a select input, free-running scan across all outputs, and a one-shot sweep with busy/done handshake. It drives row/digit/chip selects where outputs must be glitch-free, registered, and either zero or strictly one-hot.

---
 rtl/decoder_pkg.sv | 8 +
 rtl/onehot_decode.sv | 11 +
 rtl/decoder_seq.sv | 78 +++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: mode encodings and FSM state type shared by the sequenced decoder
package decoder_pkg;
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN, SWEEP} state_t;
endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: combinational SEL_W-to-2^SEL_W one-hot decoder, all zeros when disabled
module onehot_decode #(
  parameter int SEL_W = 2
) (
  input  logic                  i_en,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [2**SEL_W-1:0]   o_out
);
  localparam int N_OUT = 2**SEL_W;
  assign o_out = i_en ? {{(N_OUT-1){1'b0}}, 1'b1} << i_sel : '0;
endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with direct, scan and one-shot sweep modes
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [1:0]          i_mode,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_start,
  output logic [2**SEL_W-1:0] o_out,
  output logic [SEL_W-1:0]    o_idx,
  output logic                o_busy,
  output logic                o_done
);
  localparam int N_OUT = 2**SEL_W;
  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic [N_OUT-1:0] r_out, w_out_nxt;
  logic r_busy, r_done, w_done_nxt;
  logic w_off, w_wrap, w_end, w_cont, w_on;
  assign w_off  = !i_en || i_mode == MODE_OFF;
  assign w_wrap = r_cnt == CNT_MAX;
  assign w_end  = r_state == SWEEP && w_wrap && r_idx == {SEL_W{1'b1}};
  assign w_on   = w_state_nxt != IDLE;
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end
  // Next state: off wins, then mode; a sweep runs to completion unless mode changes
  always_comb begin
    w_state_nxt = w_off                   ? IDLE   :
                  i_mode == MODE_DIRECT   ? DIRECT :
                  i_mode == MODE_SCAN     ? SCAN   :
                  r_state == SWEEP        ? (w_end ? IDLE : SWEEP) :
                  i_start                 ? SWEEP  : IDLE;
  end
  // Next outputs: staying in scan/sweep advances the dwell, any entry restarts at index 0
  always_comb begin
    w_cont     = w_state_nxt == r_state && (r_state == SCAN || r_state == SWEEP);
    w_cnt_nxt  = (w_cont && !w_wrap) ? r_cnt + 1'b1 : '0;
    w_idx_nxt  = w_state_nxt == DIRECT ? i_sel :
                 w_cont               ? r_idx + SEL_W'(w_wrap) : '0;
    w_done_nxt = !w_off && i_mode == MODE_SWEEP && w_end;
  end
  onehot_decode #(.SEL_W(SEL_W)) u_dec (
    .i_en  (w_on),
    .i_sel (w_idx_nxt),
    .o_out (w_out_nxt)
  );
  // Datapath registers: dwell counter, index and the glitch-free output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_out  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_idx  <= w_idx_nxt;
      r_out  <= w_out_nxt;
      r_busy <= w_state_nxt == SWEEP;
      r_done <= w_done_nxt;
    end
  end
  assign o_out  = r_out;
  assign o_idx  = r_idx;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule
